// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - radix-2 iterative multiply/divide unit with HI/LO registers
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               op_div_q, op_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
        b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

        // Multiplier sits in the low half and shifts out as the product shifts in.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: a borrow out of the W+1 bit subtract means keep the remainder.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opb_q};
        div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_neg = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_div_d  = op_div;
                    neg_res_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_rem_d = is_signed & A[WIDTH-1];
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opb_d     = b_mag;
                    cnt_d     = CW'(WIDTH);
                    dbz_d     = 1'b0;
                    dz_d      = op_div && (B == '0);
                    state_d   = (op_div && (B == '0)) ? FINISH : RUN;
                end
            end
            RUN: begin
                acc_d = op_div_q ? div_step : mul_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    dbz_d = 1'b1;
                end else if (op_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_neg;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign HI          = hi_q;
    assign LO          = lo_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - directed self-checking bench for muldiv_hilo
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        is_signed;
    logic [31:0] A, B;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic [31:0] HI, LO;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    logic busy_ok;
    logic saw_done;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div),
        .is_signed(is_signed), .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .HI(HI), .LO(LO), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse on the falling edge; returns at the sample after the accepting edge.
    task automatic launch(input logic od, input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_div = od; is_signed = sg; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 32'h5A5A_1234; B = 32'h0F0F_7777;
    endtask

    task automatic wait_done(input int lat0, output int l, output logic bok);
        l = lat0;
        bok = 1'b1;
        while (!done && l < 100) begin
            if (!busy) bok = 1'b0;
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_div = 1'b0; is_signed = 1'b0;
        A = '0; B = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        // Unsigned max * max, latency and busy profile
        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, lat, busy_ok);
        chk("umul_lat", lat, 34);
        chk("umul_busy_run", busy_ok, 1);
        chk("umul_busy_done", busy, 0);
        chk("umul_hi", HI, 32'hFFFF_FFFE);
        chk("umul_lo", LO, 32'h0000_0001);
        @(negedge clk);
        chk("umul_done_pulse", done, 0);

        launch(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, lat, busy_ok);
        chk("smul_hi", HI, 32'hFFFF_FFFF);
        chk("smul_lo", LO, 32'hFFFF_FFEB);

        launch(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, lat, busy_ok);
        chk("umul2_hi", HI, 32'h0000_0006);
        chk("umul2_lo", LO, 32'hFFFF_FFEB);

        launch(1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(1, lat, busy_ok);
        chk("udiv_lat", lat, 34);
        chk("udiv_lo", LO, 32'h0000_000E);
        chk("udiv_hi", HI, 32'h0000_0002);

        launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat, busy_ok);
        chk("sdiv_lo", LO, 32'hFFFF_FFFD);
        chk("sdiv_hi", HI, 32'hFFFF_FFFF);

        launch(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, busy_ok);
        chk("sdiv_ovf_lo", LO, 32'h8000_0000);
        chk("sdiv_ovf_hi", HI, 32'h0000_0000);
        chk("sdiv_ovf_dbz", div_by_zero, 0);

        // Move-to writes in IDLE
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mt_hi", HI, 32'h1234);
        chk("mt_lo", LO, 32'h5678);

        // Divide by zero
        launch(1'b1, 1'b0, 32'd5, 32'd0);
        wait_done(1, lat, busy_ok);
        chk("dbz_lat", lat, 2);
        chk("dbz_flag", div_by_zero, 1);
        chk("dbz_hi", HI, 32'h1234);
        chk("dbz_lo", LO, 32'h5678);
        repeat (3) @(negedge clk);
        chk("dbz_sticky", div_by_zero, 1);

        // Multiply 3*4 with ignored start/hi_we while busy
        launch(1'b0, 1'b0, 32'd3, 32'd4);
        chk("dbz_cleared", div_by_zero, 0);
        repeat (8) @(negedge clk);
        start = 1'b1; op_div = 1'b1; A = 32'd9; B = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_done(10, lat, busy_ok);
        chk("busyw_lat", lat, 34);
        chk("busyw_hi", HI, 32'h0);
        chk("busyw_lo", LO, 32'h0000_000C);
        @(negedge clk);
        chk("busyw_no_requeue", busy, 0);

        hi_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        hi_we = 1'b0;
        chk("idle_hi_we", HI, 32'hDEAD);
        chk("idle_lo_keep", LO, 32'h0000_000C);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAB;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_we_hi", HI, 32'hAB);
        chk("both_we_lo", LO, 32'hAB);

        // Reset in the middle of a divide
        launch(1'b1, 1'b0, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_hi", HI, 0);
        chk("mid_rst_lo", LO, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", saw_done, 0);

        launch(1'b0, 1'b0, 32'd6, 32'd7);
        wait_done(1, lat, busy_ok);
        chk("post_rst_lo", LO, 32'h0000_002A);
        chk("post_rst_hi", HI, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
